// File: rtl/icache_refill_ctrl.sv
// Instruction-cache block refill sequencer: miss latch, memory req/grant, beat write-back, tag commit.
// Optional perf counters (refills, stall cycles) are built when ICACHE_REFILL_PERF_EN is defined.
module icache_refill_ctrl #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           miss_i,
  input  logic [ADDR_W-1:0]              miss_addr_i,
  output logic                           mem_req_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [31:0]                    mem_rdata_i,
  output logic                           rep_word_en_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] rep_word_idx_o,
  output logic [31:0]                    rep_data_o,
  output logic                           instr_cache_rep_en_o,
  output logic                           instr_miss_o,
  output logic [31:0]                    miss_count_o,
  output logic [31:0]                    stall_cycles_o
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = IDX_W + 2;

  typedef enum logic [1:0] {IDLE, REQ, RESP, COMMIT} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [IDX_W-1:0]   beat_q;
  logic               req_q;
  logic               rep_en_q;

  // Byte-offset bits of the miss address are discarded by block alignment.
  logic unused_offset;
  assign unused_offset = ^miss_addr_i[OFF_W-1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      addr_q   <= '0;
      beat_q   <= '0;
      req_q    <= 1'b0;
      rep_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_i) begin
            addr_q <= {miss_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            req_q  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            beat_q <= '0;
            req_q  <= 1'b0;
            state  <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid_i) begin
            beat_q <= beat_q + IDX_W'(1);
            if (beat_q == IDX_W'(BLOCK_WORDS - 1)) begin
              rep_en_q <= 1'b1;
              state    <= COMMIT;
            end
          end
        end
        COMMIT: begin
          rep_en_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req_o            = req_q;
  assign mem_addr_o           = addr_q;
  assign rep_word_en_o        = (state == RESP) && mem_rvalid_i;
  assign rep_word_idx_o       = beat_q;
  assign rep_data_o           = rep_word_en_o ? mem_rdata_i : 32'h0;
  assign instr_cache_rep_en_o = rep_en_q;
  // Combinational so the hazard unit stalls in the very cycle the miss is seen.
  assign instr_miss_o         = miss_i || (state != IDLE);

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] miss_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      miss_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if ((state == IDLE) && miss_i && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
      if (instr_miss_o && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign miss_count_o   = miss_cnt;
  assign stall_cycles_o = stall_cnt;
`else
  assign miss_count_o   = 32'h0;
  assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: vector table for the basic refill, hand sequences for corner cases.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss;
  logic [31:0] miss_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rep_word_en;
  logic [1:0]  rep_word_idx;
  logic [31:0] rep_data;
  logic        rep_en;
  logic        instr_miss;
  logic [31:0] miss_count;
  logic [31:0] stall_cycles;

  icache_refill_ctrl #(.BLOCK_WORDS(4), .ADDR_W(32)) dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .miss_i               (miss),
    .miss_addr_i          (miss_addr),
    .mem_req_o            (mem_req),
    .mem_addr_o           (mem_addr),
    .mem_gnt_i            (mem_gnt),
    .mem_rvalid_i         (mem_rvalid),
    .mem_rdata_i          (mem_rdata),
    .rep_word_en_o        (rep_word_en),
    .rep_word_idx_o       (rep_word_idx),
    .rep_data_o           (rep_data),
    .instr_cache_rep_en_o (rep_en),
    .instr_miss_o         (instr_miss),
    .miss_count_o         (miss_count),
    .stall_cycles_o       (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] a;
    logic        g;
    logic        v;
    logic [31:0] d;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_wen;
    logic        e_rep;
    logic        e_miss;
  } vec_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } wr_t;

  int         tests   = 0;
  int         fails   = 0;
  int         commits = 0;
  logic [1:0] exp_idx = 2'd0;
  wr_t        sbq[$];
  wr_t        w;
  vec_t       tab[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic m, input logic [31:0] a, input logic g,
                     input logic v, input logic [31:0] d);
    miss = m; miss_addr = a; mem_gnt = g; mem_rvalid = v; mem_rdata = d;
  endtask

  task automatic beat(input logic m, input logic [31:0] a, input logic [31:0] d);
    sbq.push_back(wr_t'{exp_idx, d});
    exp_idx++;
    drv(m, a, 1'b0, 1'b1, d);
  endtask

  // Minimum-latency refill; returns at the first IDLE cycle after COMMIT.
  task automatic refill(input logic [31:0] a, input logic [31:0] base);
    exp_idx = 2'd0;
    drv(1'b1, a, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("rf_miss_t0", 32'(instr_miss), 32'd1);
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk); chk("rf_req", 32'(mem_req), 32'd1);
    chk("rf_addr", mem_addr, a & 32'hFFFF_FFF0);
    tick();
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 32'h0, base + 32'(i));
      @(negedge clk);
      tick();
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("rf_commit", 32'(rep_en), 32'd1);
    tick();
  endtask

  // Scoreboard: every word write must match the oldest expected beat.
  always @(negedge clk) begin
    if (rep_word_en === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write actual idx=%0d data=%h required=none", rep_word_idx, rep_data);
      end else begin
        w = sbq.pop_front();
        chk("wr_idx", 32'(rep_word_idx), 32'(w.idx));
        chk("wr_data", rep_data, w.data);
      end
    end
    if (rep_en === 1'b1) commits++;
  end

  int c0;

  initial begin
    tab[0] = '{1'b1, 32'h1234, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 1'b1};
    tab[1] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,  1'b1, 32'h1230, 1'b0, 1'b0, 1'b1};
    tab[2] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'hA0, 1'b0, 32'h1230, 1'b1, 1'b0, 1'b1};
    tab[3] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'hA1, 1'b0, 32'h1230, 1'b1, 1'b0, 1'b1};
    tab[4] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'hA2, 1'b0, 32'h1230, 1'b1, 1'b0, 1'b1};
    tab[5] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'hA3, 1'b0, 32'h1230, 1'b1, 1'b0, 1'b1};
    tab[6] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b0, 32'h1230, 1'b0, 1'b1, 1'b1};
    tab[7] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b0, 32'h1230, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wen", 32'(rep_word_en), 32'd0);
    chk("rst_rep", 32'(rep_en), 32'd0);
    chk("rst_miss", 32'(instr_miss), 32'd0);
    chk("rst_mcnt", miss_count, 32'h0);
    chk("rst_scnt", stall_cycles, 32'h0);
    tick();

    // Single refill, cycle by cycle.
    exp_idx = 2'd0;
    for (int i = 0; i < 8; i++) begin
      if (tab[i].v) sbq.push_back(wr_t'{exp_idx++, tab[i].d});
      drv(tab[i].m, tab[i].a, tab[i].g, tab[i].v, tab[i].d);
      @(negedge clk);
      chk($sformatf("t%0d_req", i),  32'(mem_req),     32'(tab[i].e_req));
      chk($sformatf("t%0d_addr", i), mem_addr,         tab[i].e_addr);
      chk($sformatf("t%0d_wen", i),  32'(rep_word_en), 32'(tab[i].e_wen));
      chk($sformatf("t%0d_rep", i),  32'(rep_en),      32'(tab[i].e_rep));
      chk($sformatf("t%0d_miss", i), 32'(instr_miss),  32'(tab[i].e_miss));
      tick();
    end

    // Delayed grant and gappy beats.
    exp_idx = 2'd0;
    c0 = commits;
    drv(1'b1, 32'h2008, 1'b0, 1'b0, 32'h0);
    @(negedge clk); tick();
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 32'h0, (i == 3), 1'b0, 32'h0);
      @(negedge clk);
      chk("dg_req", 32'(mem_req), 32'd1);
      chk("dg_addr", mem_addr, 32'h2000);
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) beat(1'b0, 32'h0, 32'hB0 + 32'(k));
      else            drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("gap_wen", 32'(rep_word_en), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("gap_miss", 32'(instr_miss), 32'd1);
      tick();
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("dg_commit", 32'(rep_en), 32'd1);
    tick();
    @(negedge clk);
    chk("dg_idle_rep", 32'(rep_en), 32'd0);
    chk("dg_idle_miss", 32'(instr_miss), 32'd0);
    chk("dg_commits", 32'(commits - c0), 32'd1);
    tick();

    // Spurious inputs.
    exp_idx = 2'd0;
    drv(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD);
    @(negedge clk);
    chk("sp_idle_req", 32'(mem_req), 32'd0);
    chk("sp_idle_miss", 32'(instr_miss), 32'd0);
    tick();
    drv(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
    @(negedge clk); tick();
    drv(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD);
    @(negedge clk); tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk); chk("sp_req_held", 32'(mem_req), 32'd1);
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("sp_resp_wen", 32'(rep_word_en), 32'd0);
    chk("sp_resp_req", 32'(mem_req), 32'd0);
    chk("sp_resp_miss", 32'(instr_miss), 32'd1);
    tick();
    beat(1'b0, 32'h0, 32'hC0);       @(negedge clk); tick();
    beat(1'b1, 32'h5550, 32'hC1);    @(negedge clk); tick();
    beat(1'b0, 32'h0, 32'hC2);       @(negedge clk); tick();
    beat(1'b0, 32'h0, 32'hC3);       @(negedge clk); tick();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("sp_commit", 32'(rep_en), 32'd1);
    chk("sp_addr_kept", mem_addr, 32'h3000);
    tick();
    @(negedge clk);
    chk("sp_no_req", 32'(mem_req), 32'd0);
    chk("sp_idle", 32'(instr_miss), 32'd0);
    tick();

    // Reset in the middle of RESP.
    exp_idx = 2'd0;
    drv(1'b1, 32'h4000, 1'b0, 1'b0, 32'h0); tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);    tick();
    beat(1'b0, 32'h0, 32'hD0); @(negedge clk); tick();
    beat(1'b0, 32'h0, 32'hD1); @(negedge clk); tick();
    reset = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_addr", mem_addr, 32'h0);
    chk("mr_wen", 32'(rep_word_en), 32'd0);
    chk("mr_idx", 32'(rep_word_idx), 32'd0);
    chk("mr_data", rep_data, 32'h0);
    chk("mr_rep", 32'(rep_en), 32'd0);
    chk("mr_miss", 32'(instr_miss), 32'd0);
    tick();
    refill(32'h4104, 32'hE0);
    @(negedge clk); tick();

    // Back-to-back misses after a fresh reset, for the counters.
    reset = 1'b1; tick(); reset = 1'b0;
    refill(32'h0024, 32'hF0);
    refill(32'h0040, 32'h70);
    @(negedge clk);
    chk("bb_idle", 32'(instr_miss), 32'd0);
`ifdef ICACHE_REFILL_PERF_EN
    chk("bb_mcnt", miss_count, 32'd2);
    chk("bb_scnt", stall_cycles, 32'd14);
`else
    chk("bb_mcnt", miss_count, 32'd0);
    chk("bb_scnt", stall_cycles, 32'd0);
`endif
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Sequences instruction-cache block refills on a fetch miss. It latches the missing block address, runs a request/grant and response-beat handshake with the instruction memory, and writes each returned word into the cache data array. It then pulses the replacement enable that commits the tag. It sits between the instruction cache and the memory interface, and it drives the fetch-miss stall and cache-replacement signals consumed by the hazard unit.

## Interface
- `BLOCK_WORDS`, default 4: 32-bit words per cache block. Must be a power of two, ≥2.
- `ADDR_W`, default 32: byte address width.

- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `miss_i` in 1: cache lookup miss for the current fetch address.
- `miss_addr_i` in ADDR_W: fetch byte address of the miss.
- `mem_req_o` out 1: block read request.
- `mem_addr_o` out ADDR_W: block-aligned request address.
- `mem_gnt_i` in 1: memory accepts the request.
- `mem_rvalid_i` in 1: response beat valid.
- `mem_rdata_i` in 32: response beat data.
- `rep_word_en_o` out 1: write one word into the cache data array.
- `rep_word_idx_o` out $clog2(BLOCK_WORDS): word index within the block.
- `rep_data_o` out 32: word to write.
- `instr_cache_rep_en_o` out 1: one-cycle tag/valid commit pulse.
- `instr_miss_o` out 1: fetch-miss stall to the hazard unit.
- `miss_count_o` out 32: refill count (see Configuration).
- `stall_cycles_o` out 32: stall cycle count (see Configuration).

## Operation
- FSM states: IDLE, REQ, RESP, COMMIT. Reset state is IDLE.
- **IDLE**
  - When `miss_i`=1: latch `miss_addr_i` with the low log2(BLOCK_WORDS)+2 bits cleared, then go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `mem_req_o`=1 and `mem_addr_o`=latched address, both held stable until grant.
  - When `mem_gnt_i`=1: clear the beat counter, then go to RESP.
- **RESP**
  - On each `mem_rvalid_i`=1: `rep_word_en_o`=1, `rep_word_idx_o`=beat counter, `rep_data_o`=`mem_rdata_i` (combinational pass-through). The counter then increments.
  - Beats arrive in ascending word order.
  - The beat that brings the count to BLOCK_WORDS moves to COMMIT.
  - Cycles with `mem_rvalid_i`=0 hold the state.
- **COMMIT**
  - `instr_cache_rep_en_o`=1 for exactly one cycle, then go to IDLE.
- Stall: `instr_miss_o` = `miss_i` OR (state ≠ IDLE). It is combinational, so the stall begins in the miss cycle.
- Ignored inputs:
  - `miss_i` and `miss_addr_i` outside IDLE. The latched address is authoritative.
  - `mem_gnt_i` outside REQ.
  - `mem_rvalid_i` outside RESP.
- A branch redirect during a refill does not abort it. The block always completes and commits.
- Reset mid-refill:
  - Next state is IDLE and the counter clears.
  - Any in-flight memory response is the memory side's responsibility; it is reset by the same `reset_i`.

## Timing
- Reset values: all outputs 0. `mem_addr_o` is 0. Counters are 0.
- Minimum miss penalty, with grant in the first REQ cycle and back-to-back beats:
  - t0: IDLE, miss seen.
  - t1: REQ, granted.
  - t2 … t(1+BLOCK_WORDS): RESP beats.
  - t(2+BLOCK_WORDS): COMMIT.
  - t(3+BLOCK_WORDS): IDLE.
- Example: with BLOCK_WORDS=4, `instr_miss_o` is high t0–t6.
- The cycle after COMMIT the cache hits, so `miss_i`=0 and the stall drops.
- A new miss is accepted in the first IDLE cycle after COMMIT. There are no idle bubbles beyond that.

## Configuration
- `ICACHE_REFILL_PERF_EN` defined:
  - `miss_count_o` increments on every IDLE→REQ transition.
  - `stall_cycles_o` increments on every cycle `instr_miss_o`=1.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Not defined: both counters are absent and both outputs are tied to 0. The ports are present in both builds.

## Test plan
- **Single refill:** miss at 0x0000_1234, immediate grant, 4 back-to-back beats A0–A3.
  - `mem_addr_o`=0x0000_1230.
  - Word writes idx 0–3 with A0–A3.
  - `instr_cache_rep_en_o` pulses at t6.
  - `instr_miss_o` is high exactly t0–t6.
- **Delayed grant and gappy beats:** grant after 3 REQ cycles; beats with a 1-cycle gap between each.
  - `mem_addr_o` is stable throughout REQ.
  - Idx increments only on valid beats.
  - Exactly one commit pulse.
- **Spurious inputs:**
  - `mem_rvalid_i` pulsed in IDLE and REQ, `mem_gnt_i` pulsed in RESP: no word writes and no state change.
  - `miss_i` with a new address during RESP: the original address is kept.
- **Reset mid-RESP:** `reset_i` after 2 beats.
  - Next cycle: IDLE and all outputs 0.
  - A subsequent miss refills from idx 0.
- **Back-to-back misses:** a second miss at 0x40 in the cycle after COMMIT.
  - The REQ for 0x40 starts one cycle later.
  - With `ICACHE_REFILL_PERF_EN`: `miss_count_o`=2, and `stall_cycles_o` equals the summed stall cycles (14 with immediate grants).
